// File: rtl/laser_scan_ctrl.sv
// Scan scheduler: steps a candidate circle centre across a window in raster order,
// streams the point list through an external point-in-circle unit and keeps the best centre.
module laser_scan_ctrl #(
   parameter int NPTS = 40,
   parameter int AW   = 6
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          start,
   input  logic [3:0]    win_x0,
   input  logic [3:0]    win_y0,
   input  logic [3:0]    win_x1,
   input  logic [3:0]    win_y1,
   input  logic          hit,
   output logic [AW-1:0] pt_addr,
   output logic          pt_rd,
   output logic [3:0]    cand_x,
   output logic [3:0]    cand_y,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [3:0]    best_x,
   output logic [3:0]    best_y,
   output logic [5:0]    best_cnt
);

   typedef enum logic [2:0] {IDLE, SCAN, DRAIN, NEXT, FIN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          vld_q, vld_d;
   logic [5:0]    acc_q, acc_d;
   logic [3:0]    cand_x_q, cand_x_d, cand_y_q, cand_y_d;
   logic [3:0]    wx0_q, wx0_d, wy0_q, wy0_d, wx1_q, wx1_d, wy1_q, wy1_d;
   logic [3:0]    best_x_q, best_x_d, best_y_q, best_y_d;
   logic [5:0]    best_cnt_q, best_cnt_d;
   logic          err_q, err_d;

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
      state_d    = state_q;
      addr_d     = addr_q;
      vld_d      = (state_q == SCAN);
      acc_d      = acc_q;
      cand_x_d   = cand_x_q;
      cand_y_d   = cand_y_q;
      wx0_d      = wx0_q;
      wy0_d      = wy0_q;
      wx1_d      = wx1_q;
      wy1_d      = wy1_q;
      best_x_d   = best_x_q;
      best_y_d   = best_y_q;
      best_cnt_d = best_cnt_q;
      err_d      = err_q;

      // hit belongs to the address issued one cycle earlier, qualified by the delayed valid
      if (vld_q && hit) acc_d = acc_q + 6'd1;

      unique case (state_q)
         IDLE: begin
            addr_d = '0;
            if (start) begin
               wx0_d      = win_x0;
               wy0_d      = win_y0;
               wx1_d      = win_x1;
               wy1_d      = win_y1;
               acc_d      = '0;
               best_cnt_d = '0;
               best_x_d   = win_x0;
               best_y_d   = win_y0;
               cand_x_d   = win_x0;
               cand_y_d   = win_y0;
               err_d      = (win_x0 > win_x1) || (win_y0 > win_y1);
               state_d    = err_d ? FIN : SCAN;
            end
         end
         SCAN: begin
            if (addr_q == AW'(NPTS - 1)) begin
               addr_d  = '0;
               state_d = DRAIN;
            end else begin
               addr_d = addr_q + AW'(1);
            end
         end
         DRAIN: state_d = NEXT;
         NEXT: begin
            // strict compare so ties keep the earlier candidate
            if (acc_q > best_cnt_q) begin
               best_cnt_d = acc_q;
               best_x_d   = cand_x_q;
               best_y_d   = cand_y_q;
            end
            acc_d = '0;
            if (cand_x_q < wx1_q) begin
               cand_x_d = cand_x_q + 4'd1;
               state_d  = SCAN;
            end else if (cand_y_q < wy1_q) begin
               cand_x_d = wx0_q;
               cand_y_d = cand_y_q + 4'd1;
               state_d  = SCAN;
            end else begin
               state_d = FIN;
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (RST) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         vld_q      <= 1'b0;
         acc_q      <= '0;
         cand_x_q   <= '0;
         cand_y_q   <= '0;
         wx0_q      <= '0;
         wy0_q      <= '0;
         wx1_q      <= '0;
         wy1_q      <= '0;
         best_x_q   <= '0;
         best_y_q   <= '0;
         best_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         vld_q      <= vld_d;
         acc_q      <= acc_d;
         cand_x_q   <= cand_x_d;
         cand_y_q   <= cand_y_d;
         wx0_q      <= wx0_d;
         wy0_q      <= wy0_d;
         wx1_q      <= wx1_d;
         wy1_q      <= wy1_d;
         best_x_q   <= best_x_d;
         best_y_q   <= best_y_d;
         best_cnt_q <= best_cnt_d;
         err_q      <= err_d;
      end
   end

   assign pt_addr  = addr_q;
   assign pt_rd    = (state_q == SCAN);
   assign cand_x   = cand_x_q;
   assign cand_y   = cand_y_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == FIN);
   assign err      = err_q;
   assign best_x   = best_x_q;
   assign best_y   = best_y_q;
   assign best_cnt = best_cnt_q;

endmodule
